// File: rtl/hazard_control_unit.sv
// Hazard control for the F/D/E pipeline: stall enables, flushes, E-stage forwarding,
// memory-timeout error FSM and saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int TIMEOUT                = 16,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic [1:0]                        PCSrcE,
  input  logic                              MemAccessM,
  input  logic                              MemReadyM,
  output logic                              en_fetch,
  output logic                              en_decode,
  output logic                              en_execute,
  output logic                              en_memory,
  output logic                              CLR_decode,
  output logic                              CLR_execute,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              MemErr,
  output logic [CNT_WIDTH-1:0]              StallCount,
  output logic [CNT_WIDTH-1:0]              FlushCount
);

  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0]       WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic       lw_stall, redirect, mem_stall;
  logic [3:0] en_core;
  logic [1:0] clr_core;
  logic       flush_cycle, stall_cycle;

  // Register x0 is hardwired zero, so it never needs forwarding.
  function automatic logic [1:0] fwd_sel(input logic [REGISTER_ADDRESS_WIDTH-1:0] rs);
    if (RegWriteM && RdM != '0 && RdM == rs)      fwd_sel = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == rs) fwd_sel = 2'b01;
    else                                          fwd_sel = 2'b00;
  endfunction

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect  = (PCSrcE != 2'b00);
  assign mem_stall = ((state_q == ST_RUN) && MemAccessM && !MemReadyM) ||
                     ((state_q == ST_WAIT) && !MemReadyM);

  always_comb begin
    en_core     = 4'b1111;
    clr_core    = 2'b00;
    flush_cycle = 1'b0;
    if (state_q == ST_ERROR || mem_stall) begin
      en_core = 4'b0000;
    end else if (redirect) begin
      clr_core    = 2'b11;
      flush_cycle = 1'b1;
    end else if (lw_stall) begin
      en_core  = 4'b0011;
      clr_core = 2'b01;
    end
  end

  assign stall_cycle = (state_q != ST_ERROR) && !en_core[3];

  // Reset forces the pipe registers to load their cleared values.
  assign {en_fetch, en_decode, en_execute, en_memory} = rst ? 4'b1111 : en_core;
  assign {CLR_decode, CLR_execute}                    = rst ? 2'b11   : clr_core;
  assign ForwardAE  = rst ? 2'b00 : fwd_sel(Rs1E);
  assign ForwardBE  = rst ? 2'b00 : fwd_sel(Rs2E);
  assign MemErr     = mem_err_q;
  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;

    if (stall_cycle && stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_WIDTH'(1);
    if (flush_cycle && flush_count_q != CNT_MAX) flush_count_d = flush_count_q + CNT_WIDTH'(1);

    case (state_q)
      ST_RUN: begin
        if (MemAccessM && !MemReadyM) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_ERROR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two instances (TIMEOUT=16/32-bit counters and
// TIMEOUT=4/4-bit counters) share stimulus and are checked against a behavioural model.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rse;
    logic       rwm, rww;
    logic [1:0] pcs;
    logic       ma, mr;
  } stim_t;

  typedef struct packed {
    logic [3:0]  en;
    logic [1:0]  clr;
    logic [1:0]  fa, fb;
    logic        err;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1d = '0, rs2d = '0, rs1e = '0, rs2e = '0, rde = '0, rdm = '0, rdw = '0;
  logic [1:0] rse = '0, pcs = '0;
  logic rwm = 1'b0, rww = 1'b0, ma = 1'b0, mr = 1'b0;

  logic        ef_a, ed_a, ee_a, em_a, cd_a, ce_a, err_a;
  logic [1:0]  fa_a, fb_a;
  logic [31:0] sc_a, fc_a;
  logic        ef_b, ed_b, ee_b, em_b, cd_b, ce_b, err_b;
  logic [1:0]  fa_b, fb_b;
  logic [3:0]  sc_b, fc_b;

  int tests = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  bit      m_err[2], m_wait[2];
  int      m_row[2];
  longint  m_sc[2], m_fc[2];
  int      tmo[2]  = '{16, 4};
  longint  cmax[2] = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  hazard_control_unit #(.REGISTER_ADDRESS_WIDTH(5), .TIMEOUT(16), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .ResultSrcE(rse), .RegWriteM(rwm), .RegWriteW(rww),
    .PCSrcE(pcs), .MemAccessM(ma), .MemReadyM(mr),
    .en_fetch(ef_a), .en_decode(ed_a), .en_execute(ee_a), .en_memory(em_a),
    .CLR_decode(cd_a), .CLR_execute(ce_a), .ForwardAE(fa_a), .ForwardBE(fb_a),
    .MemErr(err_a), .StallCount(sc_a), .FlushCount(fc_a));

  hazard_control_unit #(.REGISTER_ADDRESS_WIDTH(5), .TIMEOUT(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .ResultSrcE(rse), .RegWriteM(rwm), .RegWriteW(rww),
    .PCSrcE(pcs), .MemAccessM(ma), .MemReadyM(mr),
    .en_fetch(ef_b), .en_decode(ed_b), .en_execute(ee_b), .en_memory(em_b),
    .CLR_decode(cd_b), .CLR_execute(ce_b), .ForwardAE(fa_b), .ForwardBE(fb_b),
    .MemErr(err_b), .StallCount(sc_b), .FlushCount(fc_b));

  function automatic logic [1:0] fwd(input stim_t s, input logic [4:0] rs);
    if (s.rwm && s.rdm != 0 && s.rdm == rs)      return 2'b10;
    else if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Model state for instance i: error flag, waiting flag, unanswered-cycle run length, counters.
  task automatic computeExpected(input int i, input stim_t s, output exp_t e);
    bit lw, redir, busy, flushed;
    lw    = (s.rse == 2'b01) && (s.rde != 0) && ((s.rde == s.rs1d) || (s.rde == s.rs2d));
    redir = (s.pcs != 2'b00);
    busy  = m_wait[i] ? !s.mr : (s.ma && !s.mr);
    flushed = 1'b0;
    e.err = m_err[i];
    e.sc  = 32'(m_sc[i]);
    e.fc  = 32'(m_fc[i]);
    if (s.rst) begin
      e.en = 4'b1111; e.clr = 2'b11; e.fa = 2'b00; e.fb = 2'b00;
      m_err[i] = 0; m_wait[i] = 0; m_row[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else begin
      e.fa = fwd(s, s.rs1e);
      e.fb = fwd(s, s.rs2e);
      if (m_err[i] || busy) begin
        e.en = 4'b0000; e.clr = 2'b00;
      end else if (redir) begin
        e.en = 4'b1111; e.clr = 2'b11; flushed = 1'b1;
      end else if (lw) begin
        e.en = 4'b0011; e.clr = 2'b01;
      end else begin
        e.en = 4'b1111; e.clr = 2'b00;
      end
      if (!m_err[i]) begin
        if (e.en[3] == 1'b0) m_sc[i] = (m_sc[i] < cmax[i]) ? m_sc[i] + 1 : cmax[i];
        if (flushed)         m_fc[i] = (m_fc[i] < cmax[i]) ? m_fc[i] + 1 : cmax[i];
        if (!m_wait[i]) begin
          if (s.ma && !s.mr) begin m_wait[i] = 1; m_row[i] = 1; end
        end else if (s.mr) begin
          m_wait[i] = 0; m_row[i] = 0;
        end else if (m_row[i] == tmo[i] - 1) begin
          m_err[i] = 1; m_wait[i] = 0;
        end else begin
          m_row[i]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = s.rst; rs1d = s.rs1d; rs2d = s.rs2d; rs1e = s.rs1e; rs2e = s.rs2e;
    rde = s.rde; rdm = s.rdm; rdw = s.rdw; rse = s.rse; rwm = s.rwm; rww = s.rww;
    pcs = s.pcs; ma = s.ma; mr = s.mr;
    computeExpected(0, s, ea);
    computeExpected(1, s, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        checkOutput("t16 en",  64'({ef_a, ed_a, ee_a, em_a}), 64'(e.en));
        checkOutput("t16 clr", 64'({cd_a, ce_a}), 64'(e.clr));
        checkOutput("t16 fwdA", 64'(fa_a), 64'(e.fa));
        checkOutput("t16 fwdB", 64'(fb_a), 64'(e.fb));
        checkOutput("t16 MemErr", 64'(err_a), 64'(e.err));
        checkOutput("t16 StallCount", 64'(sc_a), 64'(e.sc));
        checkOutput("t16 FlushCount", 64'(fc_a), 64'(e.fc));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        checkOutput("t4 en",  64'({ef_b, ed_b, ee_b, em_b}), 64'(e.en));
        checkOutput("t4 clr", 64'({cd_b, ce_b}), 64'(e.clr));
        checkOutput("t4 fwdA", 64'(fa_b), 64'(e.fa));
        checkOutput("t4 fwdB", 64'(fb_b), 64'(e.fb));
        checkOutput("t4 MemErr", 64'(err_b), 64'(e.err));
        checkOutput("t4 StallCount", 64'(sc_b), 64'(e.sc));
        checkOutput("t4 FlushCount", 64'(fc_b), 64'(e.fc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s, idle;
    idle = '0;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0; m_wait[i] = 0; m_row[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end

    s = idle; s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    s = idle; s.rdm = 5; s.rwm = 1; s.rs1e = 5; s.rdw = 5; s.rww = 1; s.rs2e = 5;
    applyStimulus(s);
    s.rdm = 0; s.rdw = 0;
    applyStimulus(s);
    s = idle; s.rdm = 6; s.rdw = 6; s.rwm = 1; s.rww = 1; s.rs1e = 6; s.rs2e = 6;
    applyStimulus(s);

    s = idle; s.rse = 2'b01; s.rde = 7; s.rs2d = 7;
    applyStimulus(s);
    applyStimulus(idle);
    s.pcs = 2'b01;
    applyStimulus(s);
    s = idle; s.rse = 2'b01; s.rde = 0; s.rs1d = 0;
    applyStimulus(s);

    s = idle; s.ma = 1; s.mr = 0;
    repeat (3) applyStimulus(s);
    s.mr = 1;
    applyStimulus(s);
    applyStimulus(idle);

    s = idle; s.ma = 1; s.mr = 0;
    repeat (6) applyStimulus(s);
    s = idle; s.pcs = 2'b10; s.rse = 2'b01; s.rde = 3; s.rs1d = 3;
    repeat (3) applyStimulus(s);
    s = idle; s.mr = 1;
    applyStimulus(s);
    s = idle; s.rst = 1;
    applyStimulus(s);
    applyStimulus(idle);

    s = idle; s.rse = 2'b01; s.rde = 9; s.rs1d = 9;
    repeat (7) applyStimulus(s);
    s = idle; s.ma = 1; s.mr = 0;
    repeat (2) applyStimulus(s);
    s = idle; s.rst = 1; s.ma = 1;
    applyStimulus(s);
    applyStimulus(idle);

    s = idle; s.pcs = 2'b11;
    repeat (20) applyStimulus(s);
    s = idle; s.rse = 2'b01; s.rde = 4; s.rs2d = 4;
    repeat (20) applyStimulus(s);

    for (int n = 0; n < 600; n++) begin
      s.rst  = ($urandom_range(0, 63) == 0);
      s.rs1d = 5'($urandom_range(0, 7));
      s.rs2d = 5'($urandom_range(0, 7));
      s.rs1e = 5'($urandom_range(0, 7));
      s.rs2e = 5'($urandom_range(0, 7));
      s.rde  = 5'($urandom_range(0, 7));
      s.rdm  = 5'($urandom_range(0, 7));
      s.rdw  = 5'($urandom_range(0, 7));
      s.rse  = 2'($urandom_range(0, 3));
      s.rwm  = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1));
      s.pcs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s.ma   = ($urandom_range(0, 2) == 0);
      s.mr   = ($urandom_range(0, 3) != 0);
      applyStimulus(s);
    end

    repeat (3) @(posedge clk);
    #1;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: %0d/%0d expectations never compared, expected 0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
